// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage instruction fields, fetch-stage enables and the registered
// ID/EX control bundle exchanged between the control unit and datapath.
interface pipe_ctrl_unit_if #(
   parameter int ALUOP_W = 5
);
   logic               id_valid;
   logic [5:0]         id_opcode;
   logic [5:0]         id_funct;
   logic [4:0]         id_rs;
   logic [4:0]         id_rt;
   logic               ext_stall;
   logic               branch_taken;
   logic               pc_write;
   logic               ifid_write;
   logic               ifid_flush;
   logic               ex_valid;
   logic               ex_reg_write;
   logic               ex_alu_src;
   logic               ex_branch;
   logic               ex_mem_write;
   logic               ex_mem_read;
   logic               ex_zero_ext;
   logic [1:0]         ex_reg_dst;
   logic [1:0]         ex_mem_to_reg;
   logic [1:0]         ex_jump;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic [4:0]         ex_rt;
   logic               illegal_op;

   modport master (
      output id_valid, id_opcode, id_funct, id_rs, id_rt, ext_stall, branch_taken,
      input  pc_write, ifid_write, ifid_flush, ex_valid, ex_reg_write, ex_alu_src,
             ex_branch, ex_mem_write, ex_mem_read, ex_zero_ext, ex_reg_dst,
             ex_mem_to_reg, ex_jump, ex_alu_op, ex_rt, illegal_op
   );

   modport slave (
      input  id_valid, id_opcode, id_funct, id_rs, id_rt, ext_stall, branch_taken,
      output pc_write, ifid_write, ifid_flush, ex_valid, ex_reg_write, ex_alu_src,
             ex_branch, ex_mem_write, ex_mem_read, ex_zero_ext, ex_reg_dst,
             ex_mem_to_reg, ex_jump, ex_alu_op, ex_rt, illegal_op
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID instruction into the ID/EX control
// register, stalls one cycle on load-use hazards and squashes wrong-path
// fetches for FLUSH_CYCLES cycles after jumps and taken branches.
module pipe_ctrl_unit #(
   parameter int ALUOP_W      = 5,
   parameter int FLUSH_CYCLES = 1,
   parameter int LOAD_USE_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   pipe_ctrl_unit_if.slave       bus
);

   typedef struct packed {
      logic               reg_write;
      logic [1:0]         reg_dst;
      logic               alu_src;
      logic               branch;
      logic               mem_write;
      logic               mem_read;
      logic [1:0]         mem_to_reg;
      logic               zero_ext;
      logic [1:0]         jump;
      logic [ALUOP_W-1:0] alu_op;
   } ctl_t;

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);
   localparam bit         LU    = (LOAD_USE_EN != 0);
   localparam bit         MULTI = (FLUSH_CYCLES > 1);

   ctl_t       dec, ctl_q;
   logic [7:0] aluc;
   logic       legal, uses_rt, hazard, is_jump;
   logic       ex_valid_q, illegal_q;
   logic [4:0] ex_rt_q;
   logic [2:0] flush_cnt;
   state_t     state;

   // Opcode decode table; unknown opcodes fall out as an all-zero bubble
   always_comb begin
      dec     = '0;
      aluc    = 8'h00;
      legal   = 1'b1;
      uses_rt = 1'b0;
      case (bus.id_opcode)
         6'h00: begin
            uses_rt = 1'b1;
            if (bus.id_funct == 6'h08) begin
               dec.jump = 2'd2; aluc = 8'h11;
            end else begin
               dec.reg_write = 1'b1; dec.reg_dst = 2'd1; dec.mem_to_reg = 2'd1;
            end
         end
         6'h1C: begin
            uses_rt = 1'b1;
            dec.reg_write = 1'b1; dec.reg_dst = 2'd1; dec.mem_to_reg = 2'd1; aluc = 8'h03;
         end
         6'h08, 6'h0A: begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 2'd1;
            aluc = (bus.id_opcode == 6'h08) ? 8'h01 : 8'h1D;
         end
         6'h0C, 6'h0D, 6'h0E: begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 2'd1; dec.zero_ext = 1'b1;
            aluc = (bus.id_opcode == 6'h0C) ? 8'h14 : (bus.id_opcode == 6'h0D) ? 8'h18 : 8'h19;
         end
         6'h23, 6'h21, 6'h20: begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
            aluc = (bus.id_opcode == 6'h23) ? 8'h01 : (bus.id_opcode == 6'h21) ? 8'h07 : 8'h08;
         end
         6'h2B, 6'h29, 6'h28: begin
            uses_rt = 1'b1;
            dec.alu_src = 1'b1; dec.mem_write = 1'b1;
            aluc = (bus.id_opcode == 6'h2B) ? 8'h01 : (bus.id_opcode == 6'h29) ? 8'h09 : 8'h06;
         end
         6'h01: begin dec.branch = 1'b1; aluc = 8'h0A; end
         6'h04: begin dec.branch = 1'b1; uses_rt = 1'b1; aluc = 8'h0B; end
         6'h05: begin dec.branch = 1'b1; uses_rt = 1'b1; aluc = 8'h0C; end
         6'h07: begin dec.branch = 1'b1; aluc = 8'h0D; end
         6'h06: begin dec.branch = 1'b1; aluc = 8'h0E; end
         6'h02: begin dec.jump = 2'd1; aluc = 8'h10; end
         6'h03: begin
            dec.reg_write = 1'b1; dec.reg_dst = 2'd2; dec.mem_to_reg = 2'd2;
            dec.jump = 2'd1; aluc = 8'h12;
         end
         default: legal = 1'b0;
      endcase
      dec.alu_op = ALUOP_W'(aluc);
   end

   // Load in EX whose destination feeds the ID instruction forces one bubble
   assign hazard = LU && ctl_q.mem_read && (ex_rt_q != 5'd0) && bus.id_valid &&
                   ((ex_rt_q == bus.id_rs) || ((ex_rt_q == bus.id_rt) && uses_rt));
   assign is_jump = bus.id_valid && legal && (dec.jump != 2'd0);

   // Fetch-stage enables, forced low during reset and external stall
   always_comb begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.ifid_flush = 1'b0;
      if (!rst && !bus.ext_stall) begin
         if (bus.branch_taken || state == FLUSH) begin
            bus.pc_write = 1'b1; bus.ifid_write = 1'b1; bus.ifid_flush = 1'b1;
         end else if (!hazard) begin
            bus.pc_write = 1'b1; bus.ifid_write = 1'b1; bus.ifid_flush = is_jump;
         end
      end
   end

   // RUN/FLUSH state machine and ID/EX control register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q      <= '0;
         ex_valid_q <= 1'b0;
         ex_rt_q    <= 5'd0;
         illegal_q  <= 1'b0;
         flush_cnt  <= 3'd0;
         state      <= RUN;
      end else if (!bus.ext_stall) begin
         ex_rt_q <= bus.id_rt;
         if (bus.branch_taken) begin
            ctl_q      <= '0;
            ex_valid_q <= 1'b0;
            flush_cnt  <= FC_M1;
            state      <= MULTI ? FLUSH : RUN;
         end else if (state == FLUSH) begin
            ctl_q      <= '0;
            ex_valid_q <= 1'b0;
            flush_cnt  <= flush_cnt - 3'd1;
            if (flush_cnt <= 3'd1) state <= RUN;
         end else if (hazard) begin
            ctl_q      <= '0;
            ex_valid_q <= 1'b0;
         end else begin
            ctl_q      <= (bus.id_valid && legal) ? dec : '0;
            ex_valid_q <= bus.id_valid && legal;
            if (bus.id_valid && !legal) illegal_q <= 1'b1;
            if (is_jump) begin
               flush_cnt <= FC_M1;
               if (MULTI) state <= FLUSH;
            end
         end
      end
   end

   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_reg_write  = ctl_q.reg_write;
   assign bus.ex_reg_dst    = ctl_q.reg_dst;
   assign bus.ex_alu_src    = ctl_q.alu_src;
   assign bus.ex_branch     = ctl_q.branch;
   assign bus.ex_mem_write  = ctl_q.mem_write;
   assign bus.ex_mem_read   = ctl_q.mem_read;
   assign bus.ex_mem_to_reg = ctl_q.mem_to_reg;
   assign bus.ex_zero_ext   = ctl_q.zero_ext;
   assign bus.ex_jump       = ctl_q.jump;
   assign bus.ex_alu_op     = ctl_q.alu_op;
   assign bus.ex_rt         = ex_rt_q;
   assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (FLUSH_CYCLES 3 and 1) share one
// stimulus stream; decode table vectors, hand-written hazard/flush/stall/reset
// sequences, then random traffic against a squash-counter reference model.
module tb_pipe_ctrl_unit;

   typedef struct packed {
      logic       rw;
      logic [1:0] rd;
      logic       asrc, br, mw, mr;
      logic [1:0] mtr;
      logic       ze;
      logic [1:0] jp;
      logic [4:0] alu;
   } ctl_t;

   typedef struct packed {
      logic       pc, ifw, ifl, v, ill;
      logic [4:0] rt;
      ctl_t       c;
   } obs_t;

   typedef struct {
      logic [5:0] op, fn;
      ctl_t       c;
   } vec_t;

   typedef struct {
      ctl_t       c;
      logic       v, ill;
      logic [4:0] rt;
      int         sq;
   } mst_t;

   localparam int NT = 22;

   logic       clk = 1'b0, rst = 1'b1;
   logic       id_valid = 1'b0, ext_stall = 1'b0, branch_taken = 1'b0;
   logic [5:0] id_opcode = 6'h00, id_funct = 6'h00;
   logic [4:0] id_rs = 5'd0, id_rt = 5'd0;
   int         checks = 0, errors = 0;
   vec_t       tbl [NT];
   mst_t       m [2];
   int         fc [2] = '{3, 1};
   obs_t       o;

   always #5 clk = ~clk;

   pipe_ctrl_unit_if #(.ALUOP_W(5)) ia ();
   pipe_ctrl_unit_if #(.ALUOP_W(5)) ib ();

   assign ia.id_valid = id_valid;   assign ib.id_valid = id_valid;
   assign ia.id_opcode = id_opcode; assign ib.id_opcode = id_opcode;
   assign ia.id_funct = id_funct;   assign ib.id_funct = id_funct;
   assign ia.id_rs = id_rs;         assign ib.id_rs = id_rs;
   assign ia.id_rt = id_rt;         assign ib.id_rt = id_rt;
   assign ia.ext_stall = ext_stall; assign ib.ext_stall = ext_stall;
   assign ia.branch_taken = branch_taken; assign ib.branch_taken = branch_taken;

   pipe_ctrl_unit #(.ALUOP_W(5), .FLUSH_CYCLES(3), .LOAD_USE_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   pipe_ctrl_unit #(.ALUOP_W(5), .FLUSH_CYCLES(1), .LOAD_USE_EN(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   function automatic obs_t obs(input int k);
      obs_t r;
      if (k == 0)
         r = {ia.pc_write, ia.ifid_write, ia.ifid_flush, ia.ex_valid, ia.illegal_op, ia.ex_rt,
              ia.ex_reg_write, ia.ex_reg_dst, ia.ex_alu_src, ia.ex_branch, ia.ex_mem_write,
              ia.ex_mem_read, ia.ex_mem_to_reg, ia.ex_zero_ext, ia.ex_jump, ia.ex_alu_op};
      else
         r = {ib.pc_write, ib.ifid_write, ib.ifid_flush, ib.ex_valid, ib.illegal_op, ib.ex_rt,
              ib.ex_reg_write, ib.ex_reg_dst, ib.ex_alu_src, ib.ex_branch, ib.ex_mem_write,
              ib.ex_mem_read, ib.ex_mem_to_reg, ib.ex_zero_ext, ib.ex_jump, ib.ex_alu_op};
      return r;
   endfunction

   function automatic vec_t mk(input logic [5:0] op, fn, input logic rw, input logic [1:0] rd,
                               input logic asrc, br, mw, mr, input logic [1:0] mtr,
                               input logic ze, input logic [1:0] jp, input logic [4:0] alu);
      vec_t r;
      r.op = op; r.fn = fn; r.c = {rw, rd, asrc, br, mw, mr, mtr, ze, jp, alu};
      return r;
   endfunction

   // Reference decode: look the opcode up in the vector table
   function automatic bit ref_dec(input logic [5:0] op, fn, output ctl_t c);
      c = '0;
      foreach (tbl[i])
         if (tbl[i].op == op && (op != 6'h00 || ((fn == 6'h08) == (tbl[i].fn == 6'h08)))) begin
            c = tbl[i].c;
            return 1'b1;
         end
      return 1'b0;
   endfunction

   function automatic bit ref_hz(input int k);
      bit uses;
      uses = id_opcode inside {6'h00, 6'h1C, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05};
      return m[k].c.mr && m[k].rt != 5'd0 && id_valid &&
             (m[k].rt == id_rs || (m[k].rt == id_rt && uses));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic setin(input logic v, input logic [5:0] op, fn, input logic [4:0] rs, rt,
                        input logic bt, st);
      id_valid = v; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt;
      branch_taken = bt; ext_stall = st;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         setin(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
         tick();
      end
   endtask

   // Check fetch-stage enables against the model before the edge
   task automatic model_comb(input int k);
      ctl_t c;
      bit   lg;
      obs_t d;
      lg = ref_dec(id_opcode, id_funct, c);
      d = obs(k);
      if (ext_stall) begin
         chk("rnd_pc", 32'(d.pc), 0); chk("rnd_ifw", 32'(d.ifw), 0); chk("rnd_ifl", 32'(d.ifl), 0);
      end else if (branch_taken || m[k].sq > 0) begin
         chk("rnd_pc", 32'(d.pc), 1); chk("rnd_ifl", 32'(d.ifl), 1);
      end else if (ref_hz(k)) begin
         chk("rnd_pc", 32'(d.pc), 0); chk("rnd_ifw", 32'(d.ifw), 0); chk("rnd_ifl", 32'(d.ifl), 0);
      end else begin
         chk("rnd_pc", 32'(d.pc), 1); chk("rnd_ifw", 32'(d.ifw), 1);
         chk("rnd_ifl", 32'(d.ifl), 32'(id_valid && lg && c.jp != 2'd0));
      end
   endtask

   // Advance the model by one clock edge
   task automatic model_upd(input int k);
      ctl_t c;
      bit   lg, hz;
      lg = ref_dec(id_opcode, id_funct, c);
      hz = ref_hz(k);
      if (!ext_stall) begin
         if (branch_taken) begin
            m[k].c = '0; m[k].v = 1'b0; m[k].sq = fc[k] - 1;
         end else if (m[k].sq > 0) begin
            m[k].c = '0; m[k].v = 1'b0; m[k].sq--;
         end else if (hz) begin
            m[k].c = '0; m[k].v = 1'b0;
         end else begin
            m[k].v = id_valid && lg;
            m[k].c = (id_valid && lg) ? c : '0;
            if (id_valid && !lg) m[k].ill = 1'b1;
            if (id_valid && lg && c.jp != 2'd0) m[k].sq = fc[k] - 1;
         end
         m[k].rt = id_rt;
      end
   endtask

   initial begin
      tbl[0]  = mk(6'h00, 6'h20, 1, 1, 0, 0, 0, 0, 1, 0, 0, 5'h00);
      tbl[1]  = mk(6'h00, 6'h08, 0, 0, 0, 0, 0, 0, 0, 0, 2, 5'h11);
      tbl[2]  = mk(6'h08, 6'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 5'h01);
      tbl[3]  = mk(6'h1C, 6'h02, 1, 1, 0, 0, 0, 0, 1, 0, 0, 5'h03);
      tbl[4]  = mk(6'h0C, 6'h00, 1, 0, 1, 0, 0, 0, 1, 1, 0, 5'h14);
      tbl[5]  = mk(6'h0D, 6'h00, 1, 0, 1, 0, 0, 0, 1, 1, 0, 5'h18);
      tbl[6]  = mk(6'h0E, 6'h00, 1, 0, 1, 0, 0, 0, 1, 1, 0, 5'h19);
      tbl[7]  = mk(6'h0A, 6'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 5'h1D);
      tbl[8]  = mk(6'h23, 6'h00, 1, 0, 1, 0, 0, 1, 0, 0, 0, 5'h01);
      tbl[9]  = mk(6'h21, 6'h00, 1, 0, 1, 0, 0, 1, 0, 0, 0, 5'h07);
      tbl[10] = mk(6'h20, 6'h00, 1, 0, 1, 0, 0, 1, 0, 0, 0, 5'h08);
      tbl[11] = mk(6'h2B, 6'h00, 0, 0, 1, 0, 1, 0, 0, 0, 0, 5'h01);
      tbl[12] = mk(6'h29, 6'h00, 0, 0, 1, 0, 1, 0, 0, 0, 0, 5'h09);
      tbl[13] = mk(6'h28, 6'h00, 0, 0, 1, 0, 1, 0, 0, 0, 0, 5'h06);
      tbl[14] = mk(6'h01, 6'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'h0A);
      tbl[15] = mk(6'h04, 6'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'h0B);
      tbl[16] = mk(6'h05, 6'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'h0C);
      tbl[17] = mk(6'h07, 6'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'h0D);
      tbl[18] = mk(6'h06, 6'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'h0E);
      tbl[19] = mk(6'h02, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'h10);
      tbl[20] = mk(6'h03, 6'h00, 1, 2, 0, 0, 0, 0, 2, 0, 1, 5'h12);
      tbl[21] = mk(6'h00, 6'h25, 1, 1, 0, 0, 0, 0, 1, 0, 0, 5'h00);

      // Reset: enables low even with a branch and valid instruction presented
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
         o = obs(k);
         chk("rst_pc", 32'(o.pc), 0); chk("rst_ifw", 32'(o.ifw), 0); chk("rst_ifl", 32'(o.ifl), 0);
         chk("rst_v", 32'(o.v), 0); chk("rst_ill", 32'(o.ill), 0); chk("rst_ctl", 32'(o.c), 0);
      end
      tick();
      rst = 1'b0;

      // addi
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("addi_pc", 32'(obs(0).pc), 1);
      tick();
      o = obs(0);
      chk("addi_ctl", 32'(o.c), 32'(tbl[2].c)); chk("addi_v", 32'(o.v), 1); chk("addi_pc2", 32'(o.pc), 1);

      // Load-use on rs
      setin(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 1'b0, 1'b0); tick();
      setin(1'b1, 6'h00, 6'h20, 5'd5, 5'd0, 1'b0, 1'b0);
      chk("lu_pc", 32'(obs(0).pc), 0); chk("lu_ifw", 32'(obs(0).ifw), 0); chk("lu_pc_b", 32'(obs(1).pc), 0);
      tick();
      chk("lu_bubble", 32'(obs(0).v), 0);
      #1 chk("lu_resume_pc", 32'(obs(0).pc), 1);
      tick();
      o = obs(0);
      chk("lu_add_v", 32'(o.v), 1); chk("lu_add_alu", 32'(o.c.alu), 0); chk("lu_add_rw", 32'(o.c.rw), 1);
      // Load to r0 never stalls
      setin(1'b1, 6'h23, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      setin(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("lu_r0_pc", 32'(obs(0).pc), 1);
      tick();
      chk("lu_r0_v", 32'(obs(0).v), 1);
      // rt match: store uses rt, addi does not
      setin(1'b1, 6'h23, 6'h00, 5'd0, 5'd6, 1'b0, 1'b0); tick();
      setin(1'b1, 6'h2B, 6'h00, 5'd1, 5'd6, 1'b0, 1'b0);
      chk("lu_sw_pc", 32'(obs(0).pc), 0);
      tick(); tick();
      chk("lu_sw_v", 32'(obs(0).v), 1); chk("lu_sw_mw", 32'(obs(0).c.mw), 1);
      setin(1'b1, 6'h23, 6'h00, 5'd0, 5'd6, 1'b0, 1'b0); tick();
      setin(1'b1, 6'h08, 6'h00, 5'd1, 5'd6, 1'b0, 1'b0);
      chk("lu_addi_pc", 32'(obs(0).pc), 1);
      tick();
      chk("lu_addi_v", 32'(obs(0).v), 1);

      // Taken branch: 3 squash cycles on A, 1 on B
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b1, 1'b0);
      chk("br_ifl_a", 32'(obs(0).ifl), 1); chk("br_pc_a", 32'(obs(0).pc), 1); chk("br_ifl_b", 32'(obs(1).ifl), 1);
      tick();
      chk("br_v_a", 32'(obs(0).v), 0); chk("br_v_b", 32'(obs(1).v), 0);
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("br_ifl_seq_a", 32'(obs(0).ifl), (i < 2) ? 1 : 0);
         if (i == 0) chk("br_ifl2_b", 32'(obs(1).ifl), 0);
         tick();
         chk("br_v_seq_a", 32'(obs(0).v), (i < 2) ? 0 : 1);
         if (i == 0) chk("br_v2_b", 32'(obs(1).v), 1);
         #1;
      end
      // Branch and jump together: jump squashed
      setin(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 1'b1, 1'b0); tick();
      chk("brj_v_b", 32'(obs(1).v), 0); chk("brj_jp_b", 32'(obs(1).c.jp), 0);
      setin(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("brj_ifl_b", 32'(obs(1).ifl), 0);
      idle(3);

      // Jump on B (1 squash cycle), A enters FLUSH
      setin(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("j_ifl_b", 32'(obs(1).ifl), 1);
      tick();
      chk("j_jp_b", 32'(obs(1).c.jp), 1); chk("j_v_b", 32'(obs(1).v), 1); chk("j_jp_a", 32'(obs(0).c.jp), 1);
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("j_ifl2_b", 32'(obs(1).ifl), 0); chk("j_ifl2_a", 32'(obs(0).ifl), 1);
      tick();
      chk("j_next_v_a", 32'(obs(0).v), 0);
      idle(3);

      // Stall freezes a valid EX instruction
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      setin(1'b1, 6'h23, 6'h00, 5'd0, 5'd3, 1'b0, 1'b1); tick();
      chk("st_ctl_b", 32'(obs(1).c), 32'(tbl[2].c)); chk("st_v_b", 32'(obs(1).v), 1);

      // Stall held 4 cycles during FLUSH with 2 squash cycles left
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd7, 1'b1, 1'b0); tick();
      for (int i = 0; i < 4; i++) begin
         setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd9, 1'b0, 1'b1);
         o = obs(0);
         chk("sf_ifl", 32'(o.ifl), 0); chk("sf_pc", 32'(o.pc), 0); chk("sf_ifw", 32'(o.ifw), 0);
         tick();
         chk("sf_rt", 32'(obs(0).rt), 7); chk("sf_v", 32'(obs(0).v), 0);
      end
      for (int i = 0; i < 3; i++) begin
         setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd9, 1'b0, 1'b0);
         chk("sf_rel_ifl", 32'(obs(0).ifl), (i < 2) ? 1 : 0);
         tick();
         chk("sf_rel_v", 32'(obs(0).v), (i < 2) ? 0 : 1);
      end

      // Illegal opcode is sticky; async reset mid-flush clears everything
      setin(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      chk("ill_v", 32'(obs(0).v), 0); chk("ill_a", 32'(obs(0).ill), 1); chk("ill_b", 32'(obs(1).ill), 1);
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      chk("ill_sticky", 32'(obs(0).ill), 1); chk("ill_next_v", 32'(obs(0).v), 1);
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b1, 1'b0); tick();
      setin(1'b1, 6'h08, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("mr_inflush", 32'(obs(0).ifl), 1);
      rst = 1'b1;
      #1;
      o = obs(0);
      chk("mr_pc", 32'(o.pc), 0); chk("mr_ifl", 32'(o.ifl), 0); chk("mr_v", 32'(o.v), 0);
      chk("mr_ill", 32'(o.ill), 0); chk("mr_ctl", 32'(o.c), 0);
      rst = 1'b0;
      #1;
      chk("mr_run_ifl", 32'(obs(0).ifl), 0); chk("mr_run_pc", 32'(obs(0).pc), 1);
      tick();
      chk("mr_run_v", 32'(obs(0).v), 1);

      // Decode table on both instances
      for (int i = 0; i < NT; i++) begin
         setin(1'b1, tbl[i].op, tbl[i].fn, 5'd0, 5'd0, 1'b0, 1'b0);
         tick();
         for (int k = 0; k < 2; k++) begin
            o = obs(k);
            chk($sformatf("tbl%0d_ctl", i), 32'(o.c), 32'(tbl[i].c));
            chk($sformatf("tbl%0d_v", i), 32'(o.v), 1);
         end
         idle(3);
      end

      // Random traffic against the reference model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m[k].c = '0; m[k].v = 1'b0; m[k].ill = 1'b0; m[k].rt = 5'd0; m[k].sq = 0;
      end
      for (int n = 0; n < 400; n++) begin
         int idx;
         idx = $urandom_range(0, NT - 1);
         if ($urandom_range(0, 39) == 0)
            setin($urandom_range(0, 99) < 85, 6'h3F, 6'h00, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
         else
            setin($urandom_range(0, 99) < 85, tbl[idx].op, tbl[idx].fn, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
         for (int k = 0; k < 2; k++) model_comb(k);
         tick();
         for (int k = 0; k < 2; k++) begin
            model_upd(k);
            o = obs(k);
            chk("rnd_ctl", 32'(o.c), 32'(m[k].c));
            chk("rnd_v", 32'(o.v), 32'(m[k].v));
            chk("rnd_rt", 32'(o.rt), 32'(m[k].rt));
            chk("rnd_ill", 32'(o.ill), 32'(m[k].ill));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the single-cycle opcode decoder for the pipelined MIPS/SAD datapath.
- Decodes the ID-stage instruction and registers the control bundle into the ID/EX boundary. Only ID/EX control fields are held here; the datapath owns operand registers.
- Detects load-use hazards and inserts bubbles.
- Squashes wrong-path instructions after jumps and taken branches for a configurable number of cycles.
- Drives pc_write, ifid_write and ifid_flush for the fetch stage.

Parameters:
ALUOP_W, 5, width of ALU operation code (values below are zero-extended to this width)
FLUSH_CYCLES, 1, IF/ID squash cycles after a jump or taken branch (legal 1..7)
LOAD_USE_EN, 1, 1 = detect load-use hazards; 0 = never stall for them

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  6  instr[31:26]
id_funct  in  6  instr[5:0]
id_rs  in  5  instr[25:21]
id_rt  in  5  instr[20:16]
ext_stall  in  1  downstream stall (memory busy); freezes everything
branch_taken  in  1  EX-stage branch resolved taken this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID register this edge
ex_valid  out  1  ID/EX holds a real instruction
ex_reg_write, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_zero_ext  out  1 each  registered controls
ex_reg_dst, ex_mem_to_reg, ex_jump  out  2 each  registered controls
ex_alu_op  out  ALUOP_W  registered ALU code
ex_rt  out  5  registered rt (load destination for hazard compare)
illegal_op  out  1  sticky; set when a valid ID instruction has an undecoded opcode

Behaviour:
- Decode table is combinational. Fields are RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemToReg, ZeroExt, Jump, ALUOp.
  - R-type (0x00): 1,1,0,0,0,0,1,0,0,0x00. Exception: funct 0x08 (jr) gives all zero, Jump=2, ALUOp 0x11.
  - addi 0x08: 1,0,1,0,0,0,1,0,0,0x01.
  - mul 0x1C: as R-type, ALUOp 0x03.
  - andi 0x0C / ori 0x0D / xori 0x0E: RegWrite=1, ALUSrc=1, MemToReg=1, ZeroExt=1; ALUOp 0x14 / 0x18 / 0x19.
  - slti 0x0A: as addi, ALUOp 0x1D.
  - lw 0x23 / lh 0x21 / lb 0x20: RegWrite=1, ALUSrc=1, MemRead=1, MemToReg=0; ALUOp 0x01 / 0x07 / 0x08.
  - sw 0x2B / sh 0x29 / sb 0x28: ALUSrc=1, MemWrite=1; ALUOp 0x01 / 0x09 / 0x06.
  - Branches, each Branch=1: regimm 0x01 ALUOp 0x0A, beq 0x04 0x0B, bne 0x05 0x0C, bgtz 0x07 0x0D, blez 0x06 0x0E.
  - j 0x02: Jump=1, ALUOp 0x10.
  - jal 0x03: RegWrite=1, RegDst=2, MemToReg=2, Jump=1, ALUOp 0x12.
  - Any other opcode decodes to a bubble and sets illegal_op if id_valid.
- Bubble means every ex_* control output = 0 and ex_valid = 0. ex_rt is still loaded.
- Reset: all ex_* outputs 0, illegal_op 0, flush counter 0, state RUN. pc_write, ifid_write and ifid_flush are combinational and read 0 while rst is high.
- Latency: decoded controls appear on ex_* one cycle after the edge at which ID holds the instruction.
- State machine RUN / FLUSH. flush_cnt is 3 bits.
- Priority each cycle, highest first:
  1. ext_stall: ID/EX, flush_cnt and state hold. pc_write=0, ifid_write=0, ifid_flush=0. A branch_taken seen during ext_stall is not lost: the source holds it until the stall ends.
  2. branch_taken: ifid_flush=1, pc_write=1, bubble into ID/EX, flush_cnt<=FLUSH_CYCLES-1, state<=(FLUSH_CYCLES>1 ? FLUSH : RUN).
  3. state FLUSH: ID instruction treated as invalid. Bubble into ID/EX, ifid_flush=1, decrement flush_cnt. Enter RUN when flush_cnt reaches 0 after the decrement.
  4. load-use hazard. Condition: LOAD_USE_EN && ex_mem_read && ex_rt!=0 && id_valid && (ex_rt==id_rs || (ex_rt==id_rt && ID uses rt as a source)). ID uses rt for R-type, mul, stores, beq and bne. Response: pc_write=0, ifid_write=0, bubble into ID/EX. Stalls exactly one cycle.
  5. normal: pc_write=1, ifid_write=1, ID/EX loads the decode (bubble if !id_valid).
     - If the ID instruction is j, jal or jr, it enters EX normally and simultaneously ifid_flush=1, flush_cnt<=FLUSH_CYCLES-1, state<=FLUSH if FLUSH_CYCLES>1.
- A simultaneous branch_taken and ID jump: branch wins and the jump is squashed.
- Reset asserted mid-flush or mid-stall: returns to RUN immediately, no residual bubbles.

Test Plan:
- Reset, then addi (0x08) with id_valid -> next cycle ex_reg_write=1, ex_alu_src=1, ex_mem_to_reg=1, ex_alu_op=0x01, ex_valid=1; pc_write=1 throughout.
- lw with rt=5 in EX, then add with rs=5 in ID -> one cycle with pc_write=0, ifid_write=0, ex_valid=0. Next cycle the add is registered with ex_alu_op=0x00. Repeat with rt=0 -> no stall.
- FLUSH_CYCLES=3, branch_taken pulse -> ifid_flush high exactly 3 consecutive cycles, 3 bubbles reach EX, then RUN resumes.
- j (0x02) in ID with FLUSH_CYCLES=1 -> ex_jump=1 next cycle, ifid_flush high one cycle, following instruction never reaches EX with ex_valid=1.
- ext_stall held 4 cycles during FLUSH with flush_cnt=2 -> ex_* frozen, ifid_flush=0 while stalled. After release the flush completes its remaining 2 cycles.
- Opcode 0x3F with id_valid -> bubble and illegal_op=1, sticky until rst. Assert rst mid-flush -> all outputs 0 asynchronously.
